// File: rtl/ysyx_22040386_if_id_buf.sv
// IF/ID decoupling buffer: small circular FIFO of {pc, inst} pairs with flush and load-use hold.
// Optional performance counters are enabled by defining YSYX_22040386_IFID_PERF_EN.
module ysyx_22040386_if_id_buf #(
   parameter int                DEPTH    = 2,
   parameter int                PC_W     = 64,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
   input  logic                     i_IFID_clk,
   input  logic                     i_IFID_rst,
   input  logic                     i_IFID_in_valid,
   output logic                     o_IFID_in_ready,
   input  logic [PC_W-1:0]          i_IFID_pc,
   input  logic [INST_W-1:0]        i_IFID_inst,
   input  logic                     i_IFID_flush,
   input  logic                     i_IFID_load_use_flag,
   input  logic                     i_IFID_out_ready,
   output logic                     o_IFID_out_valid,
   output logic [PC_W-1:0]          o_IFID_pc,
   output logic [INST_W-1:0]        o_IFID_inst,
   output logic [4:0]               o_IFID_rs1_addr,
   output logic [4:0]               o_IFID_rs2_addr,
   output logic [4:0]               o_IFID_rd_addr,
   output logic [$clog2(DEPTH):0]   o_IFID_count
`ifdef YSYX_22040386_IFID_PERF_EN
   ,
   output logic [31:0]              o_IFID_flush_cnt,
   output logic [31:0]              o_IFID_stall_cnt,
   output logic [31:0]              o_IFID_full_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   logic [PC_W-1:0]   r_pc_mem   [DEPTH];
   logic [INST_W-1:0] r_inst_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == C_FULL);
   assign w_empty = (r_count == '0);

   assign o_IFID_in_ready  = !w_full;
   assign o_IFID_out_valid = !w_empty;
   assign o_IFID_count     = r_count;

   // in_ready depends on count alone, so a pop never frees a slot for a push in the same cycle
   assign w_push = i_IFID_in_valid & o_IFID_in_ready & !i_IFID_flush;
   assign w_pop  = o_IFID_out_valid & i_IFID_out_ready & !i_IFID_load_use_flag & !i_IFID_flush;

   always_ff @(posedge i_IFID_clk) begin
      if (i_IFID_rst || i_IFID_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is never cleared; emptiness masks stale contents at the output.
   always_ff @(posedge i_IFID_clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= i_IFID_pc;
         r_inst_mem[r_wr_ptr] <= i_IFID_inst;
      end
   end

   assign o_IFID_pc       = w_empty ? '0       : r_pc_mem[r_rd_ptr];
   assign o_IFID_inst     = w_empty ? NOP_INST : r_inst_mem[r_rd_ptr];
   assign o_IFID_rs1_addr = o_IFID_inst[19:15];
   assign o_IFID_rs2_addr = o_IFID_inst[24:20];
   assign o_IFID_rd_addr  = o_IFID_inst[11:7];

`ifdef YSYX_22040386_IFID_PERF_EN
   logic [31:0] r_flush_cnt;
   logic [31:0] r_stall_cnt;
   logic [31:0] r_full_cnt;

   always_ff @(posedge i_IFID_clk) begin
      if (i_IFID_rst) begin
         r_flush_cnt <= '0;
         r_stall_cnt <= '0;
         r_full_cnt  <= '0;
      end else begin
         if (i_IFID_flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
         if (o_IFID_out_valid && !w_pop && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (!o_IFID_in_ready && (r_full_cnt != 32'hFFFF_FFFF)) begin
            r_full_cnt <= r_full_cnt + 32'd1;
         end
      end
   end

   assign o_IFID_flush_cnt = r_flush_cnt;
   assign o_IFID_stall_cnt = r_stall_cnt;
   assign o_IFID_full_cnt  = r_full_cnt;
`endif

endmodule

// File: doc/ysyx_22040386_if_id_buf.md
Name: ysyx_22040386_if_id_buf

Overview:
- Decoupling buffer and pipeline register between the instruction-fetch stage and the decode stage of the 5-stage RV64 pipeline.
- Captures each fetched {pc, inst} pair into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake.
- Early-decodes register-file read addresses from the head entry.
- Supports flush on taken branch and hold on load-use hazard.

Parameters:
DEPTH, 2, number of entries; power of two, >= 2
PC_W, 64, program-counter width
INST_W, 32, instruction width
NOP_INST, 32'h0000_0013, instruction presented when the buffer is empty (addi x0,x0,0)

Ports:
i_IFID_clk  input  1  clock; all state updates on rising edge
i_IFID_rst  input  1  synchronous reset, active-high
i_IFID_in_valid  input  1  fetch stage presents a valid {pc, inst}
o_IFID_in_ready  output  1  buffer can accept an entry this cycle
i_IFID_pc  input  PC_W  fetched PC
i_IFID_inst  input  INST_W  fetched instruction
i_IFID_flush  input  1  taken branch/jump: discard all buffered entries
i_IFID_load_use_flag  input  1  decode must hold: no pop this cycle
i_IFID_out_ready  input  1  decode stage accepts the head entry
o_IFID_out_valid  output  1  head entry valid
o_IFID_pc  output  PC_W  head PC
o_IFID_inst  output  INST_W  head instruction
o_IFID_rs1_addr  output  5  o_IFID_inst[19:15]
o_IFID_rs2_addr  output  5  o_IFID_inst[24:20]
o_IFID_rd_addr  output  5  o_IFID_inst[11:7]
o_IFID_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: DEPTH-entry register array; write pointer, read pointer, and occupancy counter. Pointers wrap modulo DEPTH.
- push = i_IFID_in_valid & o_IFID_in_ready & !i_IFID_flush.
- pop = o_IFID_out_valid & i_IFID_out_ready & !i_IFID_load_use_flag & !i_IFID_flush.
- o_IFID_in_ready = (count != DEPTH). Combinational from count only; there is no full-bypass, so when full, a same-cycle pop does not enable a push.
- o_IFID_out_valid = (count != 0).
- Head outputs come directly from storage at the read pointer; no combinational path from input to output.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1 if the buffer was empty.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Empty: o_IFID_inst = NOP_INST, o_IFID_pc = 0, and the address outputs derive from NOP_INST (rs1=0, rs2=0, rd=0).
- Flush has priority over everything. In the flush cycle, no push and no pop occur. Next cycle: count=0, pointers=0, out_valid=0, in_ready=1. Storage contents need not be cleared.
- Load-use: pop is suppressed and the head is held stable. Push continues while not full.
- Reset: count=0, wr_ptr=0, rd_ptr=0, o_IFID_out_valid=0, o_IFID_in_ready=1, o_IFID_pc=0, o_IFID_inst=NOP_INST, o_IFID_count=0.
  - Reset overrides flush, push, and pop.
  - Reset asserted mid-operation discards all entries on the next edge.
- Order is strictly FIFO; no entry is ever duplicated or dropped except by flush or reset.

Optional Feature:
- Macro: YSYX_22040386_IFID_PERF_EN.
- When defined, adds three output ports, each a 32-bit saturating counter cleared by reset:
  - o_IFID_flush_cnt: cycles with i_IFID_flush=1
  - o_IFID_stall_cnt: cycles with out_valid=1 but no pop
  - o_IFID_full_cnt: cycles with in_ready=0
- Counters saturate at 32'hFFFF_FFFF.
- When not defined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset then idle → out_valid=0, inst=32'h0000_0013, pc=0, in_ready=1, count=0.
- Push pc=0x8000_0000, inst=0x0010_0093 with out_ready=0 → next cycle out_valid=1, pc=0x8000_0000, rs1=0, rd=1, count=1.
- Push 3 entries (0x8000_0000/04/08) with out_ready=0 and DEPTH=2 → in_ready=0 after 2 pushes, the third is held upstream. Then out_ready=1 → pops in order 0x8000_0000, 0x8000_0004, and 0x8000_0008 is accepted afterwards.
- Full buffer plus i_IFID_flush=1 with in_valid=1 → next cycle count=0, out_valid=0, the pushed entry is discarded; push resumes the following cycle.
- Head 0x8000_0010 with load_use_flag=1 and out_ready=1 for 2 cycles → head stays 0x8000_0010, count unchanged. Flag drops → pop next edge.
- Reset asserted while count=2 and push/pop active → next cycle all outputs at reset values.
